writeback_scoreboard: RTL and testbench

- Initiator side of the register-file write port: owns rd_addr/rd_data/rd_we into the register file.
- Merges single-cycle ALU results and long-latency LSU results onto the single write port.
- Tracks destination registers of outstanding long-latency ops in a 32-bit busy scoreboard and stalls issue on RAW/WAW hazards.
- Sits between the issue stage and the register file.

---
 rtl/writeback_scoreboard.sv | 132 +++++++++++++
 tb/tb_writeback_scoreboard.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/writeback_scoreboard.sv
// Register-file write port arbiter (ALU over LSU) with a busy scoreboard that
// stalls issue on RAW/WAW hazards against outstanding long-latency results.

module wb_busy_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic set,
  input  logic clr,
  output logic busy
);
  // Set wins over clear; only reachable if a WAW stall is bypassed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   busy <= 1'b0;
    else if (set) busy <= 1'b1;
    else if (clr) busy <= 1'b0;
  end
endmodule

module writeback_scoreboard #(
  parameter int MAX_PENDING  = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        issue_valid,
  input  logic        issue_long,
  input  logic [4:0]  issue_rd,
  input  logic [4:0]  issue_rs1,
  input  logic [4:0]  issue_rs2,
  output logic        issue_stall,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        lsu_valid,
  output logic        lsu_ready,
  input  logic [4:0]  lsu_rd,
  input  logic [31:0] lsu_data,
  output logic [4:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic        rd_we,
  output logic [31:0] busy_mask,
  output logic [3:0]  pending_cnt,
  output logic        err_unexpected
);
  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [3:0]    MAXP = 4'(MAX_PENDING);
  localparam logic [SW-1:0] SLIM = SW'(STARVE_LIMIT);

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
    logic        lsu;
  } wb_req_t;

  logic          wb_lsu;
  logic [SW-1:0] starve;
  logic          lsu_hs, issue_acc, long_acc, hazard;
  logic [31:1]   busy_set, busy_clr;
  wb_req_t       wb_nxt;
  logic [3:0]    pend_nxt;

  assign lsu_ready = !alu_valid;
  assign lsu_hs    = lsu_valid && lsu_ready;

  assign hazard = busy_mask[issue_rs1] || busy_mask[issue_rs2] || busy_mask[issue_rd]
               || (issue_long && pending_cnt == MAXP)
               || (starve == SLIM);
  assign issue_stall = issue_valid && hazard;
  assign issue_acc   = issue_valid && !hazard;
  assign long_acc    = issue_acc && issue_long;

  // Busy clears on the edge that commits an LSU write into the register file,
  // so an issue in the following cycle already sees the new value.
  assign busy_mask[0] = 1'b0;
  for (genvar n = 1; n < 32; n++) begin : g_busy
    assign busy_set[n] = long_acc && (issue_rd == 5'(n));
    assign busy_clr[n] = rd_we && wb_lsu && (rd_addr == 5'(n));
    wb_busy_cell u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .set   (busy_set[n]),
      .clr   (busy_clr[n]),
      .busy  (busy_mask[n])
    );
  end

  always_comb begin
    wb_nxt = '{addr: rd_addr, data: rd_data, lsu: 1'b0};
    if (alu_valid)   wb_nxt = '{addr: alu_rd, data: alu_data, lsu: 1'b0};
    else if (lsu_hs) wb_nxt = '{addr: lsu_rd, data: lsu_data, lsu: 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr <= '0;
      rd_data <= '0;
      rd_we   <= 1'b0;
      wb_lsu  <= 1'b0;
    end else begin
      rd_addr <= wb_nxt.addr;
      rd_data <= wb_nxt.data;
      rd_we   <= alu_valid || lsu_hs;
      wb_lsu  <= wb_nxt.lsu;
    end
  end

  // A return with nothing outstanding is flagged, never allowed to wrap.
  always_comb begin
    pend_nxt = pending_cnt;
    if (long_acc && !(lsu_hs && pending_cnt != 4'd0))
      pend_nxt = pending_cnt + 4'd1;
    else if (!long_acc && lsu_hs && pending_cnt != 4'd0)
      pend_nxt = pending_cnt - 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_cnt    <= '0;
      err_unexpected <= 1'b0;
    end else begin
      pending_cnt <= pend_nxt;
      if (lsu_hs && pending_cnt == 4'd0) err_unexpected <= 1'b1;
    end
  end

  // Saturated starve count stalls issue so the ALU drains and the LSU gets through.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     starve <= '0;
    else if (lsu_hs || !lsu_valid)  starve <= '0;
    else if (starve != SLIM)        starve <= starve + SW'(1);
  end
endmodule

// File: tb/tb_writeback_scoreboard.sv
// Self-checking bench: expected register-file writes are queued as the
// arbitration inputs are driven and compared as rd_we pulses appear.

module tb_writeback_scoreboard;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid, issue_long;
  logic [4:0]  issue_rd, issue_rs1, issue_rs2;
  logic        issue_stall;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        lsu_valid, lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        rd_we;
  logic [31:0] busy_mask;
  logic [3:0]  pending_cnt;
  logic        err_unexpected;

  int errs = 0;
  int checks = 0;
  logic [36:0] sb_q[$];

  always #5 clk = ~clk;

  writeback_scoreboard #(.MAX_PENDING(4), .STARVE_LIMIT(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_long(issue_long), .issue_rd(issue_rd),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_stall(issue_stall),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_we(rd_we),
    .busy_mask(busy_mask), .pending_cnt(pending_cnt), .err_unexpected(err_unexpected)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Model: ALU has strict priority; LSU wins only when ALU is idle.
  always @(posedge clk) begin
    if (rst_n) begin
      if (alu_valid)      sb_q.push_back({alu_rd, alu_data});
      else if (lsu_valid) sb_q.push_back({lsu_rd, lsu_data});
    end
  end

  always @(posedge clk) begin
    logic [36:0] e;
    #1;
    if (rst_n && rd_we) begin
      if (sb_q.size() == 0) check("wr_extra", 32'(rd_addr), 32'hFFFF_FFFF);
      else begin
        e = sb_q.pop_front();
        check("wr_addr", 32'(rd_addr), 32'(e[36:32]));
        check("wr_data", rd_data, e[31:0]);
      end
    end
  end

  task automatic idle_inputs();
    issue_valid = 0; issue_long = 0; issue_rd = 0; issue_rs1 = 0; issue_rs2 = 0;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic issue(input logic lng, input logic [4:0] rd, rs1, rs2);
    issue_valid = 1; issue_long = lng; issue_rd = rd; issue_rs1 = rs1; issue_rs2 = rs2;
  endtask

  task automatic lsu(input logic [4:0] rd, input logic [31:0] d);
    lsu_valid = 1; lsu_rd = rd; lsu_data = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0;
    idle_inputs();
    step(2);
    check("rst_we", 32'(rd_we), 0);
    check("rst_busy", busy_mask, 0);
    check("rst_pend", 32'(pending_cnt), 0);
    check("rst_err", 32'(err_unexpected), 0);
    rst_n = 1;
    step();

    // RAW on a long result, cleared one edge after the LSU write
    issue(1, 5, 0, 0); #1 check("t1_acc", 32'(issue_stall), 0);
    step();
    check("t1_busy", busy_mask, 32'h20);
    check("t1_pend", 32'(pending_cnt), 1);
    issue(0, 6, 5, 0); #1 check("t1_raw", 32'(issue_stall), 1);
    issue_valid = 0;
    lsu(5, 32'hDEADBEEF); #1 check("t1_rdy", 32'(lsu_ready), 1);
    step();
    lsu_valid = 0;
    check("t1_we", 32'(rd_we), 1);
    check("t1_busy_hold", busy_mask, 32'h20);
    check("t1_pend0", 32'(pending_cnt), 0);
    issue(0, 6, 5, 0); #1 check("t1_raw2", 32'(issue_stall), 1);
    step();
    check("t1_busy_clr", busy_mask, 0);
    #1 check("t1_nostall", 32'(issue_stall), 0);
    step();
    idle_inputs();

    // ALU and LSU collide: ALU first, LSU next cycle
    issue(1, 7, 0, 0); step(); issue_valid = 0;
    alu_valid = 1; alu_rd = 3; alu_data = 32'h33;
    lsu(7, 32'h77); #1 check("t2_rdy0", 32'(lsu_ready), 0);
    step();
    alu_valid = 0; #1 check("t2_rdy1", 32'(lsu_ready), 1);
    step(); lsu_valid = 0;
    step();
    check("t2_busy", busy_mask, 0);
    check("t2_pend", 32'(pending_cnt), 0);

    // LSU starved by ALU for STARVE_LIMIT cycles throttles issue
    issue(1, 8, 0, 0); step();
    issue(0, 10, 0, 0);
    lsu(8, 32'h88);
    for (int i = 0; i < 4; i++) begin
      alu_valid = 1; alu_rd = 9; alu_data = 32'h900 + 32'(i);
      #1 check($sformatf("t3_stall%0d", i), 32'(issue_stall), (i == 3) ? 1 : 0);
      step();
    end
    alu_valid = 0; issue_valid = 0;
    step();
    lsu_valid = 0;
    issue(0, 10, 0, 0); #1 check("t3_release", 32'(issue_stall), 0);
    check("t3_pend", 32'(pending_cnt), 0);
    step(); idle_inputs(); step();

    // Pending limit
    for (int r = 1; r <= 4; r++) begin issue(1, 5'(r), 0, 0); step(); end
    check("t4_pend4", 32'(pending_cnt), 4);
    check("t4_busy", busy_mask, 32'h1E);
    issue(1, 11, 0, 0); #1 check("t4_full", 32'(issue_stall), 1);
    issue(0, 12, 0, 0); #1 check("t4_alu_ok", 32'(issue_stall), 0);
    step();
    check("t4_pend_keep", 32'(pending_cnt), 4);
    issue_valid = 0;
    lsu(1, 32'h101); step();
    check("t4_pend3", 32'(pending_cnt), 3);
    issue(1, 11, 0, 0); lsu(2, 32'h202);
    #1 check("t4_sim_acc", 32'(issue_stall), 0);
    step();
    issue_valid = 0;
    check("t4_sim_pend", 32'(pending_cnt), 3);
    check("t4_sim_busy", busy_mask, 32'h81C);
    lsu(3, 32'h303); step();
    lsu(4, 32'h404); step();
    lsu(11, 32'hB0B); step();
    lsu_valid = 0; step();
    check("t4_drain_pend", 32'(pending_cnt), 0);
    check("t4_drain_busy", busy_mask, 0);
    check("t4_noerr", 32'(err_unexpected), 0);

    // Unexpected LSU return, then a long op to x0
    lsu(13, 32'h1313); step(); lsu_valid = 0;
    check("t5_err", 32'(err_unexpected), 1);
    check("t5_pend", 32'(pending_cnt), 0);
    step(3);
    check("t5_sticky", 32'(err_unexpected), 1);
    issue(1, 0, 0, 0); step(); issue_valid = 0;
    check("t5_x0_busy", busy_mask, 0);
    check("t5_x0_pend", 32'(pending_cnt), 1);

    // Asynchronous reset mid-stream
    issue(1, 15, 0, 0); step(); issue_valid = 0;
    check("t6_busy", busy_mask, 32'h8000);
    alu_valid = 1; alu_rd = 14; alu_data = 32'hE; step();
    alu_valid = 0;
    check("t6_we_pre", 32'(rd_we), 1);
    #2 rst_n = 0;
    #1;
    check("t6_we", 32'(rd_we), 0);
    check("t6_addr", 32'(rd_addr), 0);
    check("t6_data", rd_data, 0);
    check("t6_busy0", busy_mask, 0);
    check("t6_pend", 32'(pending_cnt), 0);
    check("t6_err", 32'(err_unexpected), 0);
    step();
    sb_q.delete();
    rst_n = 1;
    alu_valid = 1; alu_rd = 20; alu_data = 32'h2020; step();
    alu_valid = 0; step(2);

    check("sb_empty", 32'(sb_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
